mmio_uart_tx: RTL and testbench

Memory-mapped serial transmit peripheral that responds to the single-cycle MIPS core's data-memory bus (we / a / wd / rd) alongside dmem. Stores written bytes go into a small FIFO. An 8N1 UART transmitter drains the FIFO onto a serial line. The top level uses `sel` to steer `rd` between dmem and this block.

---
 rtl/mips_mmio_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/mmio_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the MIPS data bus.
// Contents: register offsets inside the 16-byte window, STATUS and CTRL bit
// positions, the UART transmit FSM state encoding and the default window base.
package mips_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0100;

  // Register offsets (a[3:0] with a[1:0] forced to zero)
  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  // STATUS layout
  localparam int STATUS_FULL_BIT   = 0;
  localparam int STATUS_EMPTY_BIT  = 1;
  localparam int STATUS_ACTIVE_BIT = 2;
  localparam int STATUS_OVF_BIT    = 3;
  localparam int STATUS_COUNT_LSB  = 4;
  localparam int STATUS_COUNT_W    = 3;

  // CTRL layout (both bits are one-shot commands)
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head output (dout shows the
// oldest entry whenever the FIFO is non-empty).
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   push, din      - write request and data; ignored when full
//   pop            - remove head entry; ignored when empty
//   flush          - drop all contents (pointers and count to zero)
//   dout           - head entry
//   full, empty    - occupancy flags
//   count          - number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem_reg[rd_ptr_reg];
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_ok) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data-memory bus.
// Bytes stored to TXDATA are queued in a FIFO and shifted out LSB first.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   we, a, wd  - bus write strobe, byte address, write data
//   rd         - read data for the window (combinational from a)
//   sel        - address falls inside this block's 16-byte window
//   txd        - serial output, idle high
//   busy       - queue non-empty or a frame in flight
module mmio_uart_tx
  import mips_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        txd,
  output logic        busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_t     state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          txd_reg;
  logic          ovf_reg;

  logic [3:0]    reg_off;
  logic          push_req;
  logic          ctrl_wr;
  logic          flush;
  logic          baud_done;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;
  logic          unused_bits;

  // Address decode: word registers, byte lane bits ignored.
  assign sel      = (a[31:4] == BASE_ADDR[31:4]);
  assign reg_off  = {a[3:2], 2'b00};
  assign push_req = we & sel & (reg_off == REG_TXDATA);
  assign ctrl_wr  = we & sel & (reg_off == REG_CTRL);
  assign flush    = ctrl_wr & wd[CTRL_FLUSH_BIT];

  assign unused_bits = ^{a[1:0], wd[31:8]};

  assign baud_done = (baud_reg == BW'(CLKS_PER_BIT - 1));
  // The head is taken when idle, or at the last cycle of a stop bit so the
  // next start bit follows with no gap.
  assign pop = ~fifo_empty & ((state_reg == TX_IDLE) ||
                              (state_reg == TX_STOP && baud_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                    = '0;
    status_word[STATUS_FULL_BIT]   = fifo_full;
    status_word[STATUS_EMPTY_BIT]  = fifo_empty;
    status_word[STATUS_ACTIVE_BIT] = (state_reg != TX_IDLE);
    status_word[STATUS_OVF_BIT]    = ovf_reg;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  always_comb begin
    rd = '0;
    if (sel && reg_off == REG_STATUS) begin
      rd = status_word;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins so the
  // event is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg <= 1'b0;
    end else if (push_req && fifo_full) begin
      ovf_reg <= 1'b1;
    end else if (ctrl_wr && wd[CTRL_CLR_OVF_BIT]) begin
      ovf_reg <= 1'b0;
    end
  end

  // Transmit FSM; txd is registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= TX_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          baud_reg <= '0;
          txd_reg  <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            state_reg <= TX_START;
            txd_reg   <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= TX_DATA;
            txd_reg     <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= TX_STOP;
              txd_reg   <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              txd_reg     <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (!fifo_empty) begin
              shift_reg <= fifo_dout;
              state_reg <= TX_START;
              txd_reg   <= 1'b0;
            end else begin
              state_reg <= TX_IDLE;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        default: begin
          state_reg <= TX_IDLE;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign txd  = txd_reg;
  assign busy = (state_reg != TX_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        txd;
  logic        busy;

  int total  = 0;
  int passed = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_0100),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    step();
    $display("write a=0x%08h wd=0x%08h", addr, data);
    we = 1'b0;
    a  = 32'h0;
    wd = 32'h0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
    $display("read  a=0x%08h rd=0x%08h", addr, data);
    a = 32'h0;
  endtask

  // Checks one 8N1 frame, starting at the first sample of its start bit.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic bitv;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      bitv = 1'b0;
      else if (i == 9) bitv = 1'b1;
      else             bitv = b[i-1];
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s bit%0d cyc%0d txd", tag, i, c), {31'b0, txd}, {31'b0, bitv});
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int lows;

    // Register-window decode in the idle state.
    vecs[0]  = '{1'b0, 32'h0000_0104, 32'h0,  1'b1, 32'h2};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,  1'b1, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0108, 32'h0,  1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_010C, 32'h0,  1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0107, 32'h0,  1'b1, 32'h2};
    vecs[5]  = '{1'b0, 32'h0000_0110, 32'h0,  1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0,  1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'h77, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0110, 32'h77, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0104, 32'h0,  1'b1, 32'h2};
    vecs[10] = '{1'b1, 32'h0000_010C, 32'h33, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0104, 32'h0,  1'b1, 32'h2};
    vecs[12] = '{1'b0, 32'h0000_1104, 32'h0,  1'b0, 32'h0};

    reset = 1'b1;
    we    = 1'b0;
    a     = 32'h0;
    wd    = 32'h0;
    step();
    step();
    reset = 1'b0;

    // Reset then 20 idle cycles.
    for (int i = 0; i < 20; i++) step();
    check("idle txd", {31'b0, txd}, 32'h1);
    check("idle busy", {31'b0, busy}, 32'h0);
    read_reg(32'h104, r);
    check("idle status", r, 32'h0000_0002);

    // Table-driven decode / ignored-write vectors.
    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we;
      a  = vecs[i].a;
      wd = vecs[i].wd;
      #1;
      $display("vec%0d we=%0b a=0x%08h wd=0x%08h sel=%0b rd=0x%08h",
               i, vecs[i].we, vecs[i].a, vecs[i].wd, sel, rd);
      check($sformatf("vec%0d sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
      step();
      we = 1'b0;
    end
    check("after vecs busy", {31'b0, busy}, 32'h0);
    check("after vecs txd", {31'b0, txd}, 32'h1);

    // Single frame 0x55.
    bus_write(32'h100, 32'h55);
    check("0x55 txd before pop", {31'b0, txd}, 32'h1);
    check("0x55 busy after push", {31'b0, busy}, 32'h1);
    read_reg(32'h104, r);
    check("0x55 status count1", r, 32'h0000_0010);
    step();
    expect_frame(8'h55, "f55");
    check("0x55 busy end", {31'b0, busy}, 32'h0);
    read_reg(32'h104, r);
    check("0x55 status end", r, 32'h0000_0002);

    // Back-to-back frames 0x01, 0x02.
    bus_write(32'h100, 32'h01);
    bus_write(32'h100, 32'h02);
    expect_frame(8'h01, "f01");
    expect_frame(8'h02, "f02");
    check("b2b busy end", {31'b0, busy}, 32'h0);

    // Five writes while idle: first is popped at once, all accepted.
    for (int i = 0; i < 5; i++) bus_write(32'h100, 32'hA1 + i);
    read_reg(32'h104, r);
    check("five writes status", r, 32'h0000_0045);

    // Flush mid-frame: frame A1 completes, nothing follows.
    bus_write(32'h108, 32'h1);
    read_reg(32'h104, r);
    check("flush status", r, 32'h0000_0006);
    for (int i = 0; i < 35; i++) step();
    check("flush busy before end", {31'b0, busy}, 32'h1);
    step();
    check("flush busy at end", {31'b0, busy}, 32'h0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd !== 1'b1) lows++;
      step();
    end
    check("flush no more frames", lows, 32'h0);
    read_reg(32'h104, r);
    check("flush status idle", r, 32'h0000_0002);

    // Overflow while a frame is active.
    bus_write(32'h100, 32'hC0);
    for (int i = 0; i < 6; i++) bus_write(32'h100, 32'hC1 + i);
    read_reg(32'h104, r);
    check("overflow status", r, 32'h0000_004D);
    bus_write(32'h108, 32'h2);
    read_reg(32'h104, r);
    check("ovf clear status", r, 32'h0000_0045);

    // Reset during DATA bit 3 of frame 0xC0 (that bit is 0).
    for (int i = 0; i < 11; i++) step();
    check("pre-reset data bit3", {31'b0, txd}, 32'h0);
    reset = 1'b1;
    step();
    check("mid-frame reset txd", {31'b0, txd}, 32'h1);
    check("mid-frame reset busy", {31'b0, busy}, 32'h0);
    read_reg(32'h104, r);
    check("mid-frame reset status", r, 32'h0000_0002);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (txd !== 1'b1) lows++;
    end
    check("post-reset line idle", lows, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
